clock_div_2n: RTL and testbench

Parameterised integer clock divider that derives a slower, 50 %-duty, register-driven clock from a single input clock. It produces the serial bit clock for the panel-initialisation SPI sequencer (the `st7701_init` block). Other low-rate engines can reuse it wherever a divided clock of period 2·DIV_2N input cycles is needed.

---
 rtl/clock_div_2n.sv | 43 ++++
 tb/tb_clock_div_2n.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/clock_div_2n.sv
// Integer clock divider: clk_out is a flop-driven 50 % duty clock with a
// period of 2*DIV_2N clk_in cycles, toggling every DIV_2N rising edges.
module clock_div_2n #(
  parameter int unsigned DIV_2N = 1
) (
  input  logic clk_in,
  input  logic rst_n,
  output logic clk_out
);

  localparam int unsigned CNT_W = (DIV_2N > 1) ? $clog2(DIV_2N) : 1;

  // One extra bit so DIV_2N itself (up to 2^24) is representable as the limit.
  localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(DIV_2N);

  if (DIV_2N == 0 || DIV_2N > 32'd16777216) begin : g_bad_div
    $error("clock_div_2n: DIV_2N=%0d outside legal range 1..2^24", DIV_2N);
  end

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;
  logic             wrap;

  // Wrapping on cnt+1 >= DIV_2N (rather than cnt == DIV_2N-1) also recovers
  // any out-of-range count, treating it exactly like the terminal count.
  assign cnt_inc = {1'b0, cnt} + (CNT_W + 1)'(1);
  assign wrap    = (cnt_inc >= LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else if (wrap) begin
      cnt     <= '0;
      clk_out <= ~clk_out;
    end else begin
      cnt     <= cnt_inc[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_clock_div_2n.sv
// Directed testbench for clock_div_2n: one instance per divide ratio, each
// with its own reset so scenarios can be exercised independently.
module tb_clock_div_2n;

  logic clk_in;
  logic rst1_n, rst3_n, rst4_n, rst1000_n;
  logic out1, out3, out4, out1000;

  int n_checks = 0;
  int n_pass   = 0;

  clock_div_2n #(.DIV_2N(1))    u_div1    (.clk_in(clk_in), .rst_n(rst1_n),    .clk_out(out1));
  clock_div_2n #(.DIV_2N(3))    u_div3    (.clk_in(clk_in), .rst_n(rst3_n),    .clk_out(out3));
  clock_div_2n #(.DIV_2N(4))    u_div4    (.clk_in(clk_in), .rst_n(rst4_n),    .clk_out(out4));
  clock_div_2n #(.DIV_2N(1000)) u_div1000 (.clk_in(clk_in), .rst_n(rst1000_n), .clk_out(out1000));

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Advance one clk_in rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Release one reset between edges so the next rising edge is edge 1.
  task automatic release_between_edges();
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    rst1_n = 1'b0; rst3_n = 1'b0; rst4_n = 1'b0; rst1000_n = 1'b0;
    #1;
    n_checks++;
    if ({out1, out3, out4, out1000} !== 4'b0000)
      $display("FAIL reset_initial: got %b expected 0000", {out1, out3, out4, out1000});
    else n_pass++;
    for (int e = 1; e <= 50; e++) begin
      step();
      n_checks++;
      if ({out1, out3, out4, out1000} !== 4'b0000)
        $display("FAIL reset_hold edge %0d: got %b expected 0000", e, {out1, out3, out4, out1000});
      else n_pass++;
    end
  endtask

  task automatic test_div1();
    int rises = 0;
    logic prev = 1'b0;
    release_between_edges();
    rst1_n = 1'b1;
    n_checks++;
    if (out1 !== 1'b0) $display("FAIL div1_before_edge1: got %b expected 0", out1);
    else n_pass++;
    for (int e = 1; e <= 1000; e++) begin
      step();
      if (e == 1) begin
        n_checks++;
        if (out1 !== 1'b1) $display("FAIL div1_after_edge1: got %b expected 1", out1);
        else n_pass++;
      end
      if (e == 2) begin
        n_checks++;
        if (out1 !== 1'b0) $display("FAIL div1_after_edge2: got %b expected 0", out1);
        else n_pass++;
      end
      if (!prev && out1) rises++;
      prev = out1;
    end
    n_checks++;
    if (rises != 500) $display("FAIL div1_rise_count: got %0d expected 500", rises);
    else n_pass++;
    rst1_n = 1'b0;
  endtask

  task automatic test_div3();
    logic exp_v;
    release_between_edges();
    rst3_n = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      step();
      // Rises after edges 3, 9, 15; falls after 6, 12, 18.
      exp_v = ((e / 3) % 2) == 1;
      n_checks++;
      if (out3 !== exp_v) $display("FAIL div3_edge %0d: got %b expected %b", e, out3, exp_v);
      else n_pass++;
    end
    rst3_n = 1'b0;
  endtask

  task automatic test_reset_midphase();
    logic exp_v;
    release_between_edges();
    rst4_n = 1'b1;
    for (int e = 1; e <= 6; e++) step();
    n_checks++;
    if (out4 !== 1'b1) $display("FAIL div4_high_before_pulse: got %b expected 1", out4);
    else n_pass++;
    // 2 ns low pulse well clear of any clk_in edge.
    #1 rst4_n = 1'b0;
    #1;
    n_checks++;
    if (out4 !== 1'b0) $display("FAIL div4_async_clear: got %b expected 0", out4);
    else n_pass++;
    n_checks++;
    if (u_div4.cnt !== 2'd0) $display("FAIL div4_cnt_clear: got %0d expected 0", u_div4.cnt);
    else n_pass++;
    #1 rst4_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp_v = ((e / 4) % 2) == 1;
      n_checks++;
      if (out4 !== exp_v) $display("FAIL div4_after_pulse edge %0d: got %b expected %b", e, out4, exp_v);
      else n_pass++;
    end
    rst4_n = 1'b0;
  endtask

  task automatic test_div1000();
    int  rise_edge[$];
    int  max_cnt = 0;
    int  wraps = 0;
    int  prev_cnt = 0;
    logic prev = 1'b0;
    bit  period_ok = 1'b1;
    release_between_edges();
    rst1000_n = 1'b1;
    for (int e = 1; e <= 10000; e++) begin
      step();
      if (!prev && out1000) rise_edge.push_back(e);
      prev = out1000;
      if (int'(u_div1000.cnt) > max_cnt) max_cnt = int'(u_div1000.cnt);
      if (prev_cnt == 999 && u_div1000.cnt == 10'd0) wraps++;
      prev_cnt = int'(u_div1000.cnt);
    end
    n_checks++;
    if (rise_edge.size() != 5) $display("FAIL div1000_rise_count: got %0d expected 5", rise_edge.size());
    else n_pass++;
    n_checks++;
    if (rise_edge.size() == 0 || rise_edge[0] != 1000)
      $display("FAIL div1000_first_rise: got %0d expected 1000",
               (rise_edge.size() == 0) ? -1 : rise_edge[0]);
    else n_pass++;
    for (int i = 1; i < rise_edge.size(); i++)
      if (rise_edge[i] - rise_edge[i-1] != 2000) period_ok = 1'b0;
    n_checks++;
    if (!period_ok) $display("FAIL div1000_period: got irregular spacing expected 2000");
    else n_pass++;
    n_checks++;
    if (max_cnt != 999) $display("FAIL div1000_max_cnt: got %0d expected 999", max_cnt);
    else n_pass++;
    n_checks++;
    if (wraps != 10) $display("FAIL div1000_wraps: got %0d expected 10", wraps);
    else n_pass++;
    rst1000_n = 1'b0;
  endtask

  initial begin
    test_reset();
    test_div1();
    test_div3();
    test_reset_midphase();
    test_div1000();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
